// File: rtl/key_debouncer_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, glitch filter,
// press/release strobes and optional auto-repeat per channel.
// Ports: clk_i, srst_n_i (sync, active-low), key_i[CHANNELS] raw keys,
//   key_state_o debounced level, key_pressed_stb_o / key_released_stb_o /
//   key_repeat_stb_o one-cycle strobes, any_pressed_stb_o OR of presses.
module key_debouncer_multi #(
  parameter int CHANNELS          = 4,
  parameter int CLK_FREQ_MHZ      = 10,
  parameter int GLITCH_TIME_NS    = 500,
  parameter int KEY_ACTIVE_LOW    = 0,
  parameter int REPEAT_EN         = 0,
  parameter int REPEAT_DELAY_CYC  = 20,
  parameter int REPEAT_PERIOD_CYC = 8
) (
  input  logic                clk_i,
  input  logic                srst_n_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o,
  output logic [CHANNELS-1:0] key_repeat_stb_o,
  output logic                any_pressed_stb_o
);

  localparam int GRAW =
    CLK_FREQ_MHZ * GLITCH_TIME_NS / 1000;
  localparam int GLITCH_CYC = (GRAW < 1) ? 1 : GRAW;
  localparam int CW = $clog2(GLITCH_CYC + 1);
  localparam int RMAX =
    (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
    REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic KAL = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  logic [CHANNELS-1:0] w_press_nxt;
  logic [CHANNELS-1:0] w_rel_nxt;
  logic                r_any;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]    r_sync;
    logic          r_state;
    logic          r_press;
    logic          r_rel;
    logic [CW-1:0] r_cnt;
    logic          w_p;
    logic          w_acc;

    assign w_p   = r_sync[1] ^ KAL;
    assign w_acc = (w_p != r_state) &&
                   (r_cnt == CW'(GLITCH_CYC - 1));
    assign w_press_nxt[c] = w_acc & w_p;
    assign w_rel_nxt[c]   = w_acc & ~w_p;

    always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
        r_sync  <= {2{KAL}};
        r_state <= 1'b0;
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], key_i[c]};
        r_press <= w_press_nxt[c];
        r_rel   <= w_rel_nxt[c];
        // any return to the old level restarts the count
        if (w_p == r_state) begin
          r_cnt <= '0;
        end else if (w_acc) begin
          r_state <= w_p;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign key_state_o[c]        = r_state;
    assign key_pressed_stb_o[c]  = r_press;
    assign key_released_stb_o[c] = r_rel;

    if (REPEAT_EN != 0) begin : g_rep
      rep_state_t    r_rst;
      logic [RW-1:0] r_rcnt;
      logic          r_rep;

      always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
          r_rst  <= IDLE;
          r_rcnt <= '0;
          r_rep  <= 1'b0;
        end else begin
          r_rep <= 1'b0;
          // release wins over a repeat tick on the same edge
          if (w_rel_nxt[c]) begin
            r_rst  <= IDLE;
            r_rcnt <= '0;
          end else begin
            case (r_rst)
              IDLE: begin
                if (w_press_nxt[c]) begin
                  r_rst  <= DELAY;
                  r_rcnt <= '0;
                end
              end
              DELAY: begin
                if (r_rcnt == RW'(REPEAT_DELAY_CYC - 1)) begin
                  r_rep  <= 1'b1;
                  r_rcnt <= '0;
                  r_rst  <= REPEAT;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
              REPEAT: begin
                if (r_rcnt == RW'(REPEAT_PERIOD_CYC - 1)) begin
                  r_rep  <= 1'b1;
                  r_rcnt <= '0;
                end else begin
                  r_rcnt <= r_rcnt + 1'b1;
                end
              end
              default: begin
                r_rst  <= IDLE;
                r_rcnt <= '0;
              end
            endcase
          end
        end
      end

      assign key_repeat_stb_o[c] = r_rep;
    end else begin : g_norep
      assign key_repeat_stb_o[c] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_press_nxt;
    end
  end

  assign any_pressed_stb_o = r_any;

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Bench for key_debouncer_multi: default, auto-repeat and
// active-low instances driven with directed vectors.
module tb_key_debouncer_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst_n;
  logic       srst_c_n;
  logic [3:0] key_a, key_b, key_c;
  logic [3:0] a_st, a_pr, a_rl, a_rp;
  logic [3:0] b_st, b_pr, b_rl, b_rp;
  logic [3:0] c_st, c_pr, c_rl, c_rp;
  logic       a_any, b_any, c_any;

  key_debouncer_multi u_a (
    .clk_i              (clk),
    .srst_n_i           (srst_n),
    .key_i              (key_a),
    .key_state_o        (a_st),
    .key_pressed_stb_o  (a_pr),
    .key_released_stb_o (a_rl),
    .key_repeat_stb_o   (a_rp),
    .any_pressed_stb_o  (a_any)
  );

  key_debouncer_multi #(.REPEAT_EN(1)) u_b (
    .clk_i              (clk),
    .srst_n_i           (srst_n),
    .key_i              (key_b),
    .key_state_o        (b_st),
    .key_pressed_stb_o  (b_pr),
    .key_released_stb_o (b_rl),
    .key_repeat_stb_o   (b_rp),
    .any_pressed_stb_o  (b_any)
  );

  key_debouncer_multi #(.KEY_ACTIVE_LOW(1)) u_c (
    .clk_i              (clk),
    .srst_n_i           (srst_c_n),
    .key_i              (key_c),
    .key_state_o        (c_st),
    .key_pressed_stb_o  (c_pr),
    .key_released_stb_o (c_rl),
    .key_repeat_stb_o   (c_rp),
    .any_pressed_stb_o  (c_any)
  );

  typedef struct {
    logic [3:0] key;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       any;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void add(
    input logic [3:0] k, input logic [3:0] s,
    input logic [3:0] p, input logic [3:0] r,
    input logic a);
    vec_t v;
    v.key = k; v.st = s; v.pr = p; v.rl = r; v.any = a;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int first, cnt, other, coin;
  int reps[$];
  int exp_rep[5] = '{26, 34, 42, 50, 58};
  int rel_row, pr_row;
  logic [3:0] pat;
  logic [11:0] bounce;

  initial begin
    key_a = 4'h0; key_b = 4'h0;
    key_c = 4'b1110;
    srst_n = 1'b0; srst_c_n = 1'b0;
    repeat (3) step();
    check("reset_a",
      {15'd0, a_st, a_pr, a_rl, a_rp, a_any}, 32'd0);
    check("reset_c_state", {28'd0, c_st}, 32'd0);
    srst_n = 1'b1;

    // glitch of 4 cycles, then a 5+ cycle press on ch0
    for (int i = 0; i < 4; i++) add(4'h1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(4'h1, 0, 0, 0, 0);
    add(4'h1, 4'h1, 4'h1, 0, 1);
    add(4'h1, 4'h1, 0, 0, 0);
    add(4'h1, 4'h1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      key_a = tbl[i].key;
      step();
      check($sformatf("tbl%0d", i),
        {19'd0, a_st, a_pr, a_rl, a_any},
        {19'd0, tbl[i].st, tbl[i].pr, tbl[i].rl,
         tbl[i].any});
    end

    // ch2 press then release after 20 cycles
    first = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      key_a = 4'b0101; step();
      if (a_pr != 0) begin
        cnt++;
        if (a_pr == 4'b0100 && first < 0) first = i;
      end
    end
    check("ch2_press_row", first, 6);
    check("ch2_press_cnt", cnt, 1);
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      key_a = 4'b0001; step();
      if (a_rl != 0) begin
        cnt++;
        if (a_rl == 4'b0100 && first < 0) begin
          first = i;
          check("ch2_rel_state", {28'd0, a_st}, 32'h1);
        end
      end
    end
    check("ch2_rel_row", first, 6);
    check("ch2_rel_cnt", cnt, 1);

    // bounce train on ch1
    bounce = 12'b1111_1011_1011;
    first = -1; cnt = 0; other = 0;
    for (int i = 0; i < 22; i++) begin
      pat = (i < 12) ? {3'b000, bounce[i]} : 4'b0001;
      key_a = 4'b0001 | (pat << 1);
      step();
      if (a_pr[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (a_rl[1]) other++;
    end
    check("bounce_row", first, 13);
    check("bounce_cnt", cnt, 1);
    check("bounce_rel", other, 0);

    // release all, then ch0 and ch3 together
    for (int i = 0; i < 10; i++) begin
      key_a = 4'h0; step();
    end
    check("idle_state", {28'd0, a_st}, 32'd0);
    first = -1; cnt = 0; other = 0;
    for (int i = 0; i < 12; i++) begin
      key_a = 4'b1001; step();
      if (a_pr != 0) begin
        other++;
        if (a_pr == 4'b1001) first = i;
      end
      if (a_any) cnt++;
    end
    check("simul_row", first, 6);
    check("simul_pr_cycles", other, 1);
    check("simul_any_cnt", cnt, 1);

    // auto-repeat on instance b, ch0 held 60 cycles
    pr_row = -1; rel_row = -1; coin = 0;
    for (int i = 0; i < 80; i++) begin
      key_b = (i < 60) ? 4'h1 : 4'h0;
      step();
      if (b_pr[0]) pr_row = i;
      if (b_rl[0]) rel_row = i;
      if (b_rp[0]) reps.push_back(i);
      if (b_rp[0] && (b_pr[0] || b_rl[0])) coin++;
    end
    check("rep_press_row", pr_row, 6);
    check("rep_rel_row", rel_row, 66);
    check("rep_count", reps.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < reps.size())
        check($sformatf("rep%0d_row", i), reps[i], exp_rep[i]);
      else
        check($sformatf("rep%0d_row", i), -1, exp_rep[i]);
    end
    check("rep_coincide", coin, 0);

    // active-low instance c, ch0 held low through reset
    check("c_in_reset", {28'd0, c_st}, 32'd0);
    srst_c_n = 1'b1;
    first = -1; other = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (c_pr == 4'b0001 && first < 0) first = i;
      if (c_rl != 0) other++;
    end
    check("c_press_row", first, 6);
    check("c_state_held", {28'd0, c_st}, 32'h1);
    srst_c_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (c_rl != 0) other++;
    end
    check("c_reset_state", {28'd0, c_st}, 32'd0);
    srst_c_n = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (c_pr == 4'b0001 && first < 0) first = i;
      if (c_rl != 0) other++;
    end
    check("c_repress_row", first, 6);
    check("c_no_release", other, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_debouncer_multi.md
Name: key_debouncer_multi

Overview:
- Parametrised multi-channel successor to the single-key debouncer.
- Each channel has:
  - an input synchroniser,
  - a glitch filter,
  - a debounced level output,
  - press, release and optional auto-repeat strobes.
- Sits between raw board keys/switches and control logic (menu/counter FSMs) that consumes single-cycle strobes.

Parameters:
- CHANNELS, 4: number of independent key inputs (>=1).
- CLK_FREQ_MHZ, 10: clock frequency in MHz.
- GLITCH_TIME_NS, 500: minimum stable time in ns; GLITCH_CYC = max(1, CLK_FREQ_MHZ*GLITCH_TIME_NS/1000), integer division.
- KEY_ACTIVE_LOW, 0: 1 means a raw low level means pressed; applies to all channels.
- REPEAT_EN, 0: 1 enables auto-repeat strobes.
- REPEAT_DELAY_CYC, 20: cycles from press strobe to first repeat strobe (>=1).
- REPEAT_PERIOD_CYC, 8: cycles between subsequent repeat strobes (>=1).

Ports:
- clk_i  in  1  clock
- srst_n_i  in  1  synchronous active-low reset
- key_i  in  CHANNELS  raw asynchronous key levels
- key_state_o  out  CHANNELS  debounced pressed level (1 = pressed, polarity-corrected)
- key_pressed_stb_o  out  CHANNELS  one-cycle pulse on accepted press
- key_released_stb_o  out  CHANNELS  one-cycle pulse on accepted release
- key_repeat_stb_o  out  CHANNELS  one-cycle pulse per auto-repeat tick
- any_pressed_stb_o  out  1  OR of key_pressed_stb_o

Behaviour:
- Reset:
  - Only clk_i and srst_n_i are fixed; one clock, reset sampled on the rising edge while srst_n_i=0.
  - Reset clears all outputs to 0.
  - Synchroniser flops load the not-pressed raw level (KEY_ACTIVE_LOW ? 1 : 0).
  - Glitch counters and repeat counters load 0.
  - Stable state loads not-pressed.
- Synchroniser: 2 flops per channel. p[c] = sync2[c] ^ KEY_ACTIVE_LOW is the pressed view.
- Glitch filter, per channel, evaluated each edge:
  - If p == key_state: cnt <= 0.
  - Else if cnt == GLITCH_CYC-1: key_state <= p and cnt <= 0. Assert key_pressed_stb_o (p=1) or key_released_stb_o (p=0) for exactly this one cycle.
  - Else: cnt <= cnt+1.
  - Any return to the old level before acceptance restarts the count from 0 (no hysteresis memory).
- Latency:
  - Raw change first sampled at edge t, held stable.
  - key_state_o and the strobe change at edge t+GLITCH_CYC+1.
  - With the defaults (GLITCH_CYC=5) this is 6 cycles.
- Pulse shape: a pulse shorter than GLITCH_CYC sampled cycles produces no strobe and no state change.
- Strobes: always registered. key_state_o toggles on the same edge as its strobe.
- Channel independence: channels are fully independent. Simultaneous accepts on multiple channels all strobe in the same cycle. any_pressed_stb_o is a registered OR with no added latency, derived from the same next-state values.
- Auto-repeat FSM, per channel, only when REPEAT_EN=1:
  - States: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on accepted press; rcnt <= 0.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY_CYC-1: pulse key_repeat_stb_o, rcnt <= 0, go to REPEAT.
  - REPEAT: when rcnt == REPEAT_PERIOD_CYC-1: pulse key_repeat_stb_o, rcnt <= 0.
  - Accepted release from DELAY/REPEAT -> IDLE on that same edge, with no repeat strobe on that edge.
  - Net timing: first repeat strobe comes REPEAT_DELAY_CYC cycles after the press strobe, then one every REPEAT_PERIOD_CYC.
  - A press strobe and a repeat strobe never coincide.
- REPEAT_EN=0: key_repeat_stb_o is tied 0 and the FSM is removed.
- Counter widths:
  - cnt is $clog2(GLITCH_CYC+1) bits.
  - rcnt is $clog2(max(REPEAT_DELAY_CYC,REPEAT_PERIOD_CYC)+1) bits.
  - Counters never wrap past their compare value.
- Reset mid-operation:
  - Any partial count or held key is discarded; no release strobe is generated.
  - A key still held after reset is re-accepted as a fresh press, GLITCH_CYC+1 cycles after the first post-reset sampling edge (sync chain starts from not-pressed).

Test Plan:
- Defaults, ch0 glitch: ch0 high for 4 cycles, then low -> no strobes and key_state_o[0] stays 0. Then high for 5 cycles held -> key_pressed_stb_o=4'b0001 for one cycle, 6 cycles after the first sampling edge; any_pressed_stb_o=1 in the same cycle.
- Defaults, release: hold ch2 for 20 cycles, then drop -> key_released_stb_o=4'b0100 one cycle, 6 cycles after the drop; key_state_o[2] falls on that edge.
- Bounce train: ch1 pattern 1,1,0,1,1,1,0,1,1,1,1,1 (per cycle) -> exactly one press strobe, 6 cycles after the start of the final 5-long run.
- Simultaneous: ch0 and ch3 rise on the same edge -> key_pressed_stb_o=4'b1001 in one cycle, a single any_pressed_stb_o pulse.
- REPEAT_EN=1, DELAY=20, PERIOD=8, hold ch0 for 60 cycles:
  - repeat strobes at press+20, +28, +36, +44, +52;
  - release stops repeats; none on the release edge.
- KEY_ACTIVE_LOW=1, key held low through a reset deassert:
  - key_state_o=0 during reset;
  - press strobe 6 cycles after the first post-reset edge;
  - asserting reset mid-hold clears key_state_o with no release strobe.
